// File: rtl/vit_encoder_stack_seq_if.sv
// Control bus of the ViT encoder-stack sequencer.
// master: the sequencer itself. slave: the top-level controller plus the
// shared datapath units it drives.
interface vit_encoder_stack_seq_if #(
  parameter int NUM_LAYERS = 4,
  parameter int SEQ_LEN    = 16,
  parameter int LAYER_W    = $clog2(NUM_LAYERS + 1),
  parameter int TOK_W      = $clog2(SEQ_LEN + 1)
);
  // Handshake: every start output (stage_start bit, mlp_tok_start) is a
  // single-cycle pulse. The matching done input is honoured only while the
  // sequencer waits for that unit (from the first cycle after the pulse);
  // done bits of other units, or any done seen in the pulse cycle itself,
  // are ignored. A unit signals completion with a one-cycle done pulse.
  logic               start;
  logic               abort;
  logic               norm_mode;
  logic [LAYER_W-1:0] num_layers_cfg;
  logic [5:0]         stage_done;
  logic               mlp_tok_done;
  logic [5:0]         stage_start;
  logic               mlp_tok_start;
  logic [TOK_W-1:0]   mlp_tok_idx;
  logic [LAYER_W-1:0] layer_idx;
  logic [2:0]         stage_id;
  logic               buf_sel;
  logic               busy;
  logic               done;
  logic               error;
  logic [1:0]         err_code;
  logic [2:0]         dbg_state;

  modport master (
    input  start, abort, norm_mode, num_layers_cfg, stage_done, mlp_tok_done,
    output stage_start, mlp_tok_start, mlp_tok_idx, layer_idx, stage_id,
           buf_sel, busy, done, error, err_code, dbg_state
  );

  modport slave (
    output start, abort, norm_mode, num_layers_cfg, stage_done, mlp_tok_done,
    input  stage_start, mlp_tok_start, mlp_tok_idx, layer_idx, stage_id,
           buf_sel, busy, done, error, err_code, dbg_state
  );
endinterface

// File: rtl/vit_encoder_stack_seq.sv
// Orchestration sequencer for a stack of ViT encoder layers. Steps through
// the six encoder stages per layer over shared datapath units using
// start/done handshakes, loops the MLP stage per token, flips the ping-pong
// activation buffer per layer and guards every wait with a watchdog.
// No data passes through this block.
module vit_encoder_stack_seq #(
  parameter int NUM_LAYERS = 4,
  parameter int SEQ_LEN    = 16,
  parameter int TIMEOUT    = 4096,
  parameter int LAYER_W    = $clog2(NUM_LAYERS + 1),
  parameter int TOK_W      = $clog2(SEQ_LEN + 1),
  parameter int TO_W       = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vit_encoder_stack_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_MLP_ISSUE = 3'd3,
    S_MLP_WAIT  = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  // Stage codes double as the bit positions in stage_start/stage_done.
  localparam logic [2:0] ST_MLP   = 3'd4;
  localparam logic [2:0] POS_LAST = 3'd5;

  state_t state;
  state_t state_nxt;

  // Configuration latched on an accepted start.
  logic               cfg_post;
  logic [LAYER_W-1:0] cfg_layers;

  // Run progress.
  logic [2:0]         pos;       // position inside the stage order
  logic [2:0]         stage_q;   // stage code at that position
  logic [LAYER_W-1:0] layer_q;
  logic               buf_q;
  logic [TOK_W-1:0]   tok_q;
  logic               error_q;
  logic [1:0]         err_code_q;
  logic [TO_W-1:0]    wd_cnt;

  // Decoded conditions.
  logic       accept;
  logic       cfg_bad;
  logic       waiting;
  logic       unit_done;
  logic       tok_last;
  logic       stage_fin;
  logic       last_pos;
  logic       more_layers;
  logic       timeout_hit;
  logic [2:0] next_stage;

  // Stage code found at position p of the pre-norm or post-norm order.
  // Pre-norm : LN1 ATT RES1 LN2 MLP RES2  (codes 0 1 2 3 4 5)
  // Post-norm: ATT RES1 LN1 MLP RES2 LN2  (codes 1 2 0 4 5 3)
  function automatic logic [2:0] stage_at(input logic post, input logic [2:0] p);
    logic [2:0] c;
    c = p;
    if (post) begin
      case (p)
        3'd0:    c = 3'd1;
        3'd1:    c = 3'd2;
        3'd2:    c = 3'd0;
        3'd3:    c = 3'd4;
        3'd4:    c = 3'd5;
        default: c = 3'd3;
      endcase
    end
    return c;
  endfunction

  // Condition decode shared by the FSM and the progress registers.
  always_comb begin
    accept      = ((state == S_IDLE) || (state == S_ERR)) && bus.start && !bus.abort;
    cfg_bad     = (bus.num_layers_cfg == '0) || (int'(bus.num_layers_cfg) > NUM_LAYERS);
    waiting     = (state == S_WAIT) || (state == S_MLP_WAIT);
    tok_last    = (tok_q == TOK_W'(SEQ_LEN - 1));
    unit_done   = ((state == S_WAIT) && bus.stage_done[stage_q]) ||
                  ((state == S_MLP_WAIT) && bus.mlp_tok_done);
    stage_fin   = ((state == S_WAIT) && bus.stage_done[stage_q]) ||
                  ((state == S_MLP_WAIT) && bus.mlp_tok_done && tok_last);
    last_pos    = (pos == POS_LAST);
    more_layers = (int'(layer_q) + 1) < int'(cfg_layers);
    // A done in the final watchdog cycle still counts, so timeout needs it absent.
    timeout_hit = waiting && !unit_done && (wd_cnt == TO_W'(TIMEOUT - 1));
    next_stage  = stage_at(cfg_post, pos + 3'd1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides everything else.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (bus.start) begin
            // The first stage of either order is never the MLP.
            state_nxt = cfg_bad ? S_ERR : S_ISSUE;
          end
        end
        S_ISSUE:     state_nxt = S_WAIT;
        S_MLP_ISSUE: state_nxt = S_MLP_WAIT;
        S_WAIT, S_MLP_WAIT: begin
          if (stage_fin) begin
            if (!last_pos) begin
              state_nxt = (next_stage == ST_MLP) ? S_MLP_ISSUE : S_ISSUE;
            end else if (more_layers) begin
              state_nxt = S_ISSUE;
            end else begin
              state_nxt = S_DONE;
            end
          end else if (unit_done) begin
            // MLP token finished but more tokens remain.
            state_nxt = S_MLP_ISSUE;
          end else if (timeout_hit) begin
            state_nxt = S_ERR;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state and registered progress only.
  always_comb begin
    bus.stage_start   = 6'd0;
    bus.mlp_tok_start = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    case (state)
      S_ISSUE: begin
        bus.stage_start = 6'd1 << stage_q;
        bus.busy        = 1'b1;
      end
      S_WAIT:      bus.busy = 1'b1;
      S_MLP_ISSUE: begin
        bus.mlp_tok_start = 1'b1;
        bus.busy          = 1'b1;
      end
      S_MLP_WAIT:  bus.busy = 1'b1;
      S_DONE:      bus.done = 1'b1;
      default:     bus.busy = 1'b0;
    endcase
  end

  assign bus.mlp_tok_idx = tok_q;
  assign bus.layer_idx   = layer_q;
  assign bus.stage_id    = stage_q;
  assign bus.buf_sel     = buf_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_code_q;
  assign bus.dbg_state   = state;

  // Configuration, stage/layer/token progress, watchdog and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_post   <= 1'b0;
      cfg_layers <= '0;
      pos        <= 3'd0;
      stage_q    <= 3'd0;
      layer_q    <= '0;
      buf_q      <= 1'b0;
      tok_q      <= '0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      wd_cnt     <= '0;
    end else if (bus.abort) begin
      pos        <= 3'd0;
      stage_q    <= 3'd0;
      layer_q    <= '0;
      buf_q      <= 1'b0;
      tok_q      <= '0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      wd_cnt     <= '0;
    end else if (accept) begin
      cfg_post   <= bus.norm_mode;
      cfg_layers <= bus.num_layers_cfg;
      pos        <= 3'd0;
      stage_q    <= stage_at(bus.norm_mode, 3'd0);
      layer_q    <= '0;
      buf_q      <= 1'b0;
      tok_q      <= '0;
      error_q    <= cfg_bad;
      err_code_q <= cfg_bad ? 2'd2 : 2'd0;
      wd_cnt     <= '0;
    end else begin
      // Watchdog restarts on every issue so each wait gets the full budget.
      if ((state == S_ISSUE) || (state == S_MLP_ISSUE)) begin
        wd_cnt <= '0;
      end else if (waiting) begin
        wd_cnt <= wd_cnt + TO_W'(1);
      end

      if ((state == S_MLP_WAIT) && bus.mlp_tok_done) begin
        tok_q <= tok_last ? '0 : tok_q + TOK_W'(1);
      end

      if (stage_fin) begin
        if (!last_pos) begin
          pos     <= pos + 3'd1;
          stage_q <= next_stage;
        end else if (more_layers) begin
          pos     <= 3'd0;
          stage_q <= stage_at(cfg_post, 3'd0);
          layer_q <= layer_q + LAYER_W'(1);
          buf_q   <= ~buf_q;
        end
      end else if (timeout_hit) begin
        // stage/layer/token registers stay frozen for debug.
        error_q    <= 1'b1;
        err_code_q <= 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_vit_encoder_stack_seq.sv
// Bench for the ViT encoder-stack sequencer: a reactive unit stub answers
// start pulses with queued delays, a trace model predicts every start pulse,
// done pulse and error entry with its cycle, and a monitor compares them.
module tb_vit_encoder_stack_seq;
  localparam int NL = 2;
  localparam int SL = 4;
  localparam int TO = 16;
  localparam int LW = $clog2(NL + 1);
  localparam int W  = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vit_encoder_stack_seq_if #(.NUM_LAYERS(NL), .SEQ_LEN(SL)) bus ();

  vit_encoder_stack_seq #(.NUM_LAYERS(NL), .SEQ_LEN(SL), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [5:0] stub_sd = 6'd0;
  logic       stub_td = 1'b0;
  logic       main_td = 1'b0;
  assign bus.stage_done   = stub_sd;
  assign bus.mlp_tok_done = stub_td | main_td;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           delay_q[$];
  int           run_t0 = 0;
  int           checks = 0;
  int           errors = 0;

  // Event record: {cycle, busy, kind, code, tok, layer, buf}
  // kind 0 = stage start (code = stage), 1 = token start (tok = index),
  // 2 = done, 3 = error entry (code = err_code, tok = frozen stage on timeout).
  function automatic logic [W-1:0] ev(input int t, input bit bsy, input int kind,
                                      input int code, input int tok, input int layer,
                                      input int bsel);
    return {16'(t), bsy, 2'(kind), 3'(code), 3'(tok), 2'(layer), 1'(bsel)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic observe(input logic [W-1:0] got);
    logic [W-1:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event got=%0h expected=none", got);
    end else begin
      exp = exp_q.pop_front();
      check("event", got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_err;
  initial begin
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int rel;
        int b;
        rel = cyc - run_t0;
        if (bus.stage_start != 6'd0) begin
          b = 7;
          for (int i = 0; i < 6; i++) if (bus.stage_start[i]) b = i;
          if ($countones(bus.stage_start) != 1 || b == 4) b = 7;
          observe(ev(rel, bus.busy, 0, b, 0, bus.layer_idx, bus.buf_sel));
        end
        if (bus.mlp_tok_start)
          observe(ev(rel, bus.busy, 1, 0, bus.mlp_tok_idx, bus.layer_idx, bus.buf_sel));
        if (bus.done)
          observe(ev(rel, bus.busy, 2, 0, 0, bus.layer_idx, bus.buf_sel));
        if (bus.error && (!prev_err || rel == 1))
          observe(ev(rel, bus.busy, 3, bus.err_code,
                     (bus.err_code == 2'd1) ? bus.stage_id : 3'd0,
                     bus.layer_idx, bus.buf_sel));
        prev_err = bus.error;
      end else begin
        prev_err = 1'b0;
      end
    end
  end

  // ---------------- datapath unit stub ----------------
  // Delay d: done arrives in wait cycle d (d = 0 means never answer).
  // Delays >= 2 also fake an early done in the issue cycle; delays >= 3 add
  // noise on unrelated done bits in the first wait cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (bus.stage_start != 6'd0 || bus.mlp_tok_start)) begin
        int d;
        logic is_tok;
        logic [5:0] hit;
        is_tok = bus.mlp_tok_start;
        hit    = bus.stage_start;
        d      = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
        if (!is_tok && d >= 2) stub_sd = hit;
        @(posedge clk); #1;
        stub_sd = 6'd0;
        if (d > 0) begin
          for (int w = 1; w < d; w++) begin
            stub_sd = (w == 1 && d >= 3) ? (6'($urandom_range(63, 1)) & ~hit) : 6'd0;
            @(posedge clk); #1;
          end
          stub_sd = is_tok ? 6'd0 : hit;
          stub_td = is_tok;
          @(posedge clk); #1;
          stub_sd = 6'd0;
          stub_td = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic kick(input bit post, input int cfg);
    @(posedge clk); #1;
    bus.start          = 1'b1;
    bus.norm_mode      = post;
    bus.num_layers_cfg = LW'(cfg);
    run_t0             = cyc;
    @(posedge clk); #1;
    bus.start          = 1'b0;
    bus.norm_mode      = 1'($urandom_range(1, 0));
    bus.num_layers_cfg = LW'($urandom_range(3, 0));
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL run_stalled got=%0d_pending expected=0_pending", exp_q.size());
      exp_q.delete();
    end
    delay_q.delete();
    repeat (4) @(negedge clk);
  endtask

  // mode 0: full run; 1: LN2 of the last layer never answers; 2: abort in
  // the last layer's MLP wait of token 2, together with mlp_tok_done.
  task automatic run_case(input bit post, input int cfg, input int mode,
                          input int max_d, input int att_d);
    int order[6];
    int post_ord[6];
    int t, d, code, abort_t;
    bit stop;
    post_ord = '{1, 2, 0, 4, 5, 3};
    for (int p = 0; p < 6; p++) order[p] = post ? post_ord[p] : p;
    t = 1;
    stop = 1'b0;
    abort_t = 0;
    for (int l = 0; l < cfg && !stop; l++) begin
      for (int p = 0; p < 6 && !stop; p++) begin
        code = order[p];
        for (int k = 0; k < ((code == 4) ? SL : 1) && !stop; k++) begin
          d = (code == 1 && att_d > 0) ? att_d : int'($urandom_range(max_d, 1));
          if (mode == 1 && code == 3 && l == cfg - 1) d = 0;
          if (mode == 2 && code == 4 && k == 2 && l == cfg - 1) d = 0;
          exp_q.push_back((code == 4) ? ev(t, 1, 1, 0, k, l, l % 2)
                                      : ev(t, 1, 0, code, 0, l, l % 2));
          delay_q.push_back(d);
          if (d == 0) begin
            stop = 1'b1;
            if (mode == 1) exp_q.push_back(ev(t + TO + 1, 0, 3, 1, 3, l, l % 2));
            else abort_t = t + 2;
          end else begin
            t += d + 1;
          end
        end
      end
    end
    if (!stop) exp_q.push_back(ev(t, 0, 2, 0, 0, cfg - 1, (cfg - 1) % 2));

    kick(post, cfg);

    if (mode == 2) begin
      while (cyc - run_t0 < abort_t) begin
        @(posedge clk); #1;
      end
      bus.abort = 1'b1;
      main_td   = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      main_td   = 1'b0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_tok_idx", bus.mlp_tok_idx, 0);
      check("abort_layer", bus.layer_idx, 0);
      check("abort_buf", bus.buf_sel, 0);
      check("abort_error", bus.error, 0);
    end

    drain();

    if (mode == 0) begin
      check("final_layer", bus.layer_idx, cfg - 1);
      check("final_buf", bus.buf_sel, (cfg - 1) % 2);
      check("idle_busy", bus.busy, 0);
      check("idle_error", bus.error, 0);
    end else if (mode == 1) begin
      check("to_error", bus.error, 1);
      check("to_code", bus.err_code, 1);
      check("to_stage", bus.stage_id, 3);
      check("to_layer", bus.layer_idx, cfg - 1);
      check("to_busy", bus.busy, 0);
    end
  endtask

  task automatic run_bad(input int cfg);
    exp_q.push_back(ev(1, 0, 3, 2, 0, 0, 0));
    kick(1'($urandom_range(1, 0)), cfg);
    drain();
    check("bad_error", bus.error, 1);
    check("bad_code", bus.err_code, 2);
    check("bad_busy", bus.busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.norm_mode      = 1'b0;
    bus.num_layers_cfg = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.stage_start, bus.mlp_tok_start, bus.mlp_tok_idx, bus.layer_idx,
           bus.stage_id, bus.buf_sel, bus.busy, bus.done, bus.error, bus.err_code}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_case(1'b0, 2, 0, 1, 0);   // pre-norm, minimum latency, done at 37
    run_case(1'b1, 1, 0, 1, 0);   // post-norm, minimum latency, done at 19
    run_case(1'b0, 1, 0, 2, 10);  // slow ATT with spurious done bits
    run_case(1'b1, 2, 0, 2, 10);
    run_case(1'b0, 2, 1, 2, 0);   // LN2 watchdog expiry
    run_case(1'b1, 2, 0, 3, 0);   // restart from ERR
    run_bad(0);
    run_bad(NL + 1);
    run_case(1'b0, 1, 0, 2, 0);   // restart after bad configuration
    run_case(1'b1, 2, 2, 2, 0);   // abort during MLP wait
    run_case(1'b0, 2, 0, 3, 0);   // fresh run after abort
    for (int r = 0; r < 6; r++)
      run_case(1'($urandom_range(1, 0)), int'($urandom_range(NL, 1)), 0,
               int'($urandom_range(4, 1)), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit got=expired expected=finished");
    $fatal(1, "time limit");
  end

endmodule
